// File: rtl/sha_block_feeder.sv
// sha_block_feeder: packs a fixed-length byte stream into one padded SHA-256
// block, kicks the core, waits for a fresh digest and streams it out bytewise.
module sha_block_feeder #(
  parameter int MSG_BYTES = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] sha_M,
  output logic         sha_start,
  input  logic [255:0] sha_hash,
  input  logic         sha_hash_rdy,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {COLLECT, START, WAIT, OUT} state_t;

  // 0x80 terminator right after the message, big-endian bit length in the
  // last 64 bits; everything in between is already zero in the cleared block.
  localparam logic [511:0] PAD_BLOCK =
    ({8'h80, 504'd0} >> (8 * MSG_BYTES)) | 512'(64'(MSG_BYTES) * 64'd8);
  localparam logic [5:0]  LAST_K   = 6'(MSG_BYTES - 1);
  localparam logic [15:0] LAST_TMO = 16'(TIMEOUT - 1);

  state_t         state;
  logic [5:0]     k;          // bytes accepted into the current block
  logic [15:0]    tcnt;       // WAIT cycles elapsed
  logic [4:0]     idx;        // digest byte currently presented
  logic [255:0]   shreg;      // digest, MSB byte is on out_data
  logic           hist;       // sha_hash_rdy seen on the previous edge
  logic [511:0]   m_with_byte;

  assign in_ready  = (state == COLLECT) && !rst;
  assign busy      = (state != COLLECT);
  assign out_valid = (state == OUT);
  assign out_data  = shreg[255:248];
  assign out_last  = (state == OUT) && (idx == 5'd31);

  // Block image with the incoming byte dropped into slot k.
  always_comb begin
    // NOTE: default assignment first so every path writes the variable and no latch is inferred.
    m_with_byte = sha_M;
    for (int b = 0; b < MSG_BYTES; b++) begin
      if (k == 6'(b)) m_with_byte[511 - 8*b -: 8] = in_data;
    end
  end

  // Control FSM with all datapath registers and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      k         <= '0;
      tcnt      <= '0;
      idx       <= '0;
      // NOTE: the 512-bit block is a plain register driven straight onto sha_M, so it is reset like any other state.
      sha_M     <= '0;
      shreg     <= '0;
      hist      <= 1'b0;
      sha_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      hist      <= sha_hash_rdy;
      sha_start <= 1'b0;
      err       <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            k <= k + 6'd1;
            if (k == LAST_K) begin
              sha_M     <= m_with_byte | PAD_BLOCK;
              sha_start <= 1'b1;
              state     <= START;
            end else begin
              sha_M <= m_with_byte;
            end
          end
        end
        START: begin
          // A level left high by the previous block must not look like a rise.
          hist  <= 1'b1;
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (sha_hash_rdy && !hist) begin
            shreg <= sha_hash;
            idx   <= '0;
            state <= OUT;
          end else if (tcnt == LAST_TMO) begin
            err   <= 1'b1;
            k     <= '0;
            sha_M <= '0;
            tcnt  <= '0;
            state <= COLLECT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            shreg <= {shreg[247:0], 8'h00};
            idx   <= idx + 5'd1;
            if (idx == 5'd31) begin
              k     <= '0;
              sha_M <= '0;
              state <= COLLECT;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
